// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
//   word_t    - 32-bit machine word (register file data)
//   regbits_t - 5-bit register index (32 architectural registers)
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

endpackage

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates two writeback sources onto the single register file write port.
//   Port 0 (pipeline writeback) normally has priority. Port 1 (multicycle unit) is granted
//   whenever port 0 is idle, and is forced through after STARVE_LIMIT consecutive denials.
//   One request is accepted per cycle (valid && ready). The accepted sel/dat are registered,
//   so wen/wsel/wdat appear one cycle after acceptance. Writes to register 0 are accepted but
//   never raise wen.
// Ports:
//   CLK, nRST                     - clock, asynchronous active-low reset
//   req0_valid/sel/dat, req0_ready - port 0 request, ready = accepted this cycle
//   req1_valid/sel/dat, req1_ready - port 1 request, ready = accepted this cycle
//   wen, wsel, wdat               - register file write port (registered)
module rf_wb_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     req0_valid,
  input  regbits_t req0_sel,
  input  word_t    req0_dat,
  output logic     req0_ready,
  input  logic     req1_valid,
  input  regbits_t req1_sel,
  input  word_t    req1_dat,
  output logic     req1_ready,
  output logic     wen,
  output regbits_t wsel,
  output word_t    wdat
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            starved;
  logic            gnt0, gnt1, accept;
  regbits_t        acc_sel;
  word_t           acc_dat;
  logic            wen_q;
  regbits_t        wsel_q;
  word_t           wdat_q;

  // Grants depend only on valids, the starvation counter and reset; never on the write port.
  always_comb begin
    starved = req1_valid && (cnt_q == CntMax);
    gnt1    = nRST && req1_valid && (!req0_valid || starved);
    gnt0    = nRST && req0_valid && !gnt1;
    accept  = gnt0 || gnt1;
    acc_sel = gnt1 ? req1_sel : req0_sel;
    acc_dat = gnt1 ? req1_dat : req0_dat;
  end

  // Counts consecutive denied cycles of a pending port 1 request, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!req1_valid || gnt1) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q  <= '0;
      wen_q  <= 1'b0;
      wsel_q <= '0;
      wdat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      // Register 0 is hard-wired: accept the request but suppress the write.
      wen_q <= accept && (acc_sel != '0);
      if (accept) begin
        wsel_q <= acc_sel;
        wdat_q <= acc_dat;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign wen        = wen_q;
  assign wsel       = wsel_q;
  assign wdat       = wdat_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for rf_wb_arbiter. Every expected write is pushed when the
// granting cycle is driven and popped when wen is observed; a small register file model
// captures what actually gets written.
module tb_rf_wb_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic     CLK = 1'b0;
  logic     nRST = 1'b0;
  logic     req0_valid = 1'b0, req1_valid = 1'b0;
  regbits_t req0_sel = '0, req1_sel = '0;
  word_t    req0_dat = '0, req1_dat = '0;
  logic     req0_ready, req1_ready;
  logic     wen;
  regbits_t wsel;
  word_t    wdat;

  int n_cmp = 0;
  int n_fail = 0;

  logic [36:0] sb[$];
  logic        prev_write = 1'b0;
  logic        pend0 = 1'b0, pend1 = 1'b0;
  word_t       rf[32];

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req0_valid(req0_valid),
    .req0_sel  (req0_sel),
    .req0_dat  (req0_dat),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_sel  (req1_sel),
    .req1_dat  (req1_dat),
    .req1_ready(req1_ready),
    .wen       (wen),
    .wsel      (wsel),
    .wdat      (wdat)
  );

  always #5 CLK = ~CLK;

  // Register file model: writes on the falling edge while wen is high (no reg 0 gating here,
  // so a stray wen for sel 0 would show up in rf[0]).
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(negedge CLK) if (wen === 1'b1) rf[wsel] <= wdat;

  // One arbitration cycle: check the write port for last cycle's expected write, drive new
  // requests, check readies against hand-derived grants, and push the expected write.
  task automatic step(input logic v0, input logic [4:0] s0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] s1, input logic [31:0] d1,
                      input logic er0, input logic er1, input string tag);
    logic [36:0] e;
    @(negedge CLK);
    n_cmp++;
    if (wen !== prev_write) begin
      n_fail++;
      $display("FAIL %s wen: got %b want %b", tag, wen, prev_write);
    end
    if (wen === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s unexpected write: got sel=%0d dat=%h want none", tag, wsel, wdat);
      end else begin
        e = sb.pop_front();
        if ({wsel, wdat} !== e) begin
          n_fail++;
          $display("FAIL %s write data: got sel=%0d dat=%h want sel=%0d dat=%h",
                   tag, wsel, wdat, e[36:32], e[31:0]);
        end
      end
    end
    if (pend0) begin
      n_cmp++;
      if (!v0 || s0 !== req0_sel || d0 !== req0_dat) begin
        n_fail++;
        $display("FAIL %s protocol port0: got valid=%b want held request", tag, v0);
      end
    end
    if (pend1) begin
      n_cmp++;
      if (!v1 || s1 !== req1_sel || d1 !== req1_dat) begin
        n_fail++;
        $display("FAIL %s protocol port1: got valid=%b want held request", tag, v1);
      end
    end
    req0_valid = v0; req0_sel = s0; req0_dat = d0;
    req1_valid = v1; req1_sel = s1; req1_dat = d1;
    #1;
    n_cmp++;
    if (req0_ready !== er0 || req1_ready !== er1) begin
      n_fail++;
      $display("FAIL %s ready: got %b%b want %b%b", tag, req0_ready, req1_ready, er0, er1);
    end
    pend0 = v0 && !er0;
    pend1 = v1 && !er1;
    prev_write = (er0 && s0 != 0) || (er1 && s1 != 0);
    if (er0 && s0 != 0) sb.push_back({s0, d0});
    if (er1 && s1 != 0) sb.push_back({s1, d1});
  endtask

  task automatic idle(input string tag);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, tag);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    req0_valid = 1'b1; req0_sel = 5'd2; req0_dat = 32'hAAAA_0000;
    req1_valid = 1'b1; req1_sel = 5'd3; req1_dat = 32'hBBBB_0000;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++;
    if (wen !== 1'b0 || wsel !== 5'd0 || wdat !== 32'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got wen=%b wsel=%0d wdat=%h want 0/0/0", wen, wsel, wdat);
    end
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ready: got %b%b want 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    prev_write = 1'b0;
  endtask

  task automatic test_single();
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "single");
    idle("single_wen");
    idle("single_off");
    n_cmp++;
    if (wsel !== 5'd5 || wdat !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single hold: got wsel=%0d wdat=%h want 5/deadbeef", wsel, wdat);
    end
  endtask

  task automatic test_starve();
    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'(i), 32'h100 + i, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, "starve_p0");
    step(1'b1, 5'd5, 32'h105, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, "starve_p1");
    // Counter restarted from 0: port 0 wins again against a fresh port 1 request.
    step(1'b1, 5'd5, 32'h105, 1'b1, 5'd10, 32'hA, 1'b1, 1'b0, "starve_reset_cnt");
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA, 1'b0, 1'b1, "starve_p1_idle0");
    idle("starve_drain1");
    idle("starve_drain2");
  endtask

  task automatic test_sel_zero();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, "selzero");
    idle("selzero_nowen");
    idle("selzero_idle");
    n_cmp++;
    if (rf[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL selzero reg0: got %h want 0", rf[0]);
    end
  endtask

  task automatic test_same_reg();
    step(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b1, 1'b0, "samereg_p0");
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22, 1'b0, 1'b1, "samereg_p1");
    idle("samereg_w0");
    idle("samereg_w1");
    idle("samereg_idle");
    n_cmp++;
    if (rf[7] !== 32'h22) begin
      n_fail++;
      $display("FAIL samereg reg7: got %h want 00000022", rf[7]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        step(1'b1, 5'(i + 1), 32'hB0 + i, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "b2b_p0");
      else
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'hB0 + i, 1'b0, 1'b1, "b2b_p1");
    end
    idle("b2b_drain1");
    idle("b2b_drain2");
  endtask

  task automatic test_reset_midflight();
    @(negedge CLK);
    req0_valid = 1'b1; req0_sel = 5'd12; req0_dat = 32'hAA;
    req1_valid = 1'b1; req1_sel = 5'd13; req1_dat = 32'hBB;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid ready: got %b%b want 10", req0_ready, req1_ready);
    end
    @(posedge CLK);
    #1;
    n_cmp++;
    if (wen !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid accept wen: got %b want 1", wen);
    end
    req0_valid = 1'b0;
    #1;
    nRST = 1'b0;
    #1;
    n_cmp++;
    if (wen !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid async: got wen=%b ready1=%b want 0/0", wen, req1_ready);
    end
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (rf[12] !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid reg12: got %h want 0", rf[12]);
    end
    // Release with port 1 still holding its request: it must be accepted straight away.
    nRST = 1'b1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid reaccept: got %b%b want 01", req0_ready, req1_ready);
    end
    sb.push_back({5'd13, 32'hBB});
    prev_write = 1'b1;
    pend0 = 1'b0;
    pend1 = 1'b0;
    idle("rstmid_w");
    idle("rstmid_idle");
    n_cmp++;
    if (rf[13] !== 32'hBB || rf[12] !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid regs: got r12=%h r13=%h want 0/bb", rf[12], rf[13]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_starve();
    test_sel_zero();
    test_same_reg();
    test_back_to_back();
    test_reset_midflight();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending writes want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
